// File: rtl/regfile_pkg.sv
// regfile_pkg: state encoding and default geometry shared by the register
// file and the decode/hazard logic that sizes its address and data buses.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned RF_XLEN_DEFAULT  = 32;
  localparam int unsigned RF_NREGS_DEFAULT = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per architectural register.
// Decode allocates a destination, writeback releases it, a flush clears all.
// Priority per register: flush > allocate > release > hold. Updates happen
// only while the register file is running. With ZERO_REG set, register 0 is
// never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS    = RF_NREGS_DEFAULT,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_i,
  input  logic          alloc_en_i,
  input  logic [AW-1:0] alloc_addr_i,
  input  logic          rel_en_i,
  input  logic [AW-1:0] rel_addr_i,
  input  logic          flush_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: hardwired zero, then flush, allocate, release, hold
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if ((ZERO_REG != 32'd0) && (i == 32'sd0)) begin
        busy_d[i] = 1'b0;
      end else if (!run_i) begin
        busy_d[i] = busy_q[i];
      end else if (flush_i) begin
        busy_d[i] = 1'b0;
      end else if (alloc_en_i && (alloc_addr_i == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (rel_en_i && (rel_addr_i == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Busy vector register, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with two combinational read
// ports, one synchronous write port, a post-reset clear sequencer (the array
// itself has no reset) and a busy scoreboard for RAW hazard detection.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding of the
// writeback data and release onto the read ports in the same cycle).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = RF_XLEN_DEFAULT,
  parameter  int unsigned NREGS    = RF_NREGS_DEFAULT,
  localparam int unsigned AW       = $clog2(NREGS),
  parameter  int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            flush
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] regs_q [NREGS];

  logic            arr_we_s;
  logic [AW-1:0]   arr_waddr_s;
  logic [XLEN-1:0] arr_wdata_s;

  logic                  run_s;
  logic [1:0][AW-1:0]    rd_addr_s;
  logic [1:0][XLEN-1:0]  rd_data_s;
  logic [1:0]            rd_busy_s;
  logic [1:0]            sb_busy_s;

  // True for the register that reads as zero and ignores writes
  function automatic logic is_hardwired(input logic [AW-1:0] addr);
    return (ZERO_REG != 32'd0) && (addr == {AW{1'b0}});
  endfunction

  assign run_s = (state_q == ST_RUN);

  // Clear sequencer: walk every index once, then stay in RUN until reset
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d   = ST_RUN;
          clr_idx_d = {AW{1'b0}};
          ready_d   = 1'b1;
        end else begin
          state_d   = ST_CLEAR;
          clr_idx_d = clr_idx_q + AW'(1'b1);
          ready_d   = 1'b0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = {AW{1'b0}};
        ready_d   = 1'b0;
      end
    endcase
  end

  // Sequencer state, clear index and ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= {AW{1'b0}};
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  assign ready = ready_q;

  // Array write port: clear writes own it in CLEAR, writeback owns it in RUN
  always_comb begin
    if (state_q == ST_CLEAR) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = clr_idx_q;
      arr_wdata_s = {XLEN{1'b0}};
    end else if (wr_en && !is_hardwired(wr_addr)) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = wr_addr;
      arr_wdata_s = wr_data;
    end else begin
      arr_we_s    = 1'b0;
      arr_waddr_s = wr_addr;
      arr_wdata_s = wr_data;
    end
  end

  // Register array storage; contents are initialised by the clear sequence
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      regs_q[arr_waddr_s] <= arr_wdata_s;
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run_s),
    .alloc_en_i  (alloc_en),
    .alloc_addr_i(alloc_addr),
    .rel_en_i    (wr_en),
    .rel_addr_i  (wr_addr),
    .flush_i     (flush),
    .rs1_addr_i  (rs1_addr),
    .rs2_addr_i  (rs2_addr),
    .rs1_busy_o  (sb_busy_s[0]),
    .rs2_busy_o  (sb_busy_s[1])
  );

  assign rd_addr_s[0] = rs1_addr;
  assign rd_addr_s[1] = rs2_addr;

  // Read ports: zero while clearing or on the hardwired register, else array
  always_comb begin
    rd_data_s = {(2 * XLEN){1'b0}};
    rd_busy_s = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (!run_s) begin
        rd_data_s[p] = {XLEN{1'b0}};
        rd_busy_s[p] = 1'b0;
      end else if (is_hardwired(rd_addr_s[p])) begin
        rd_data_s[p] = {XLEN{1'b0}};
        rd_busy_s[p] = 1'b0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_en && (wr_addr == rd_addr_s[p])) begin
        // Forward writeback data; a same-cycle allocation keeps the old busy
        rd_data_s[p] = wr_data;
        rd_busy_s[p] = (alloc_en && (alloc_addr == rd_addr_s[p])) ? sb_busy_s[p] : 1'b0;
`endif
      end else begin
        rd_data_s[p] = regs_q[rd_addr_s[p]];
        rd_busy_s[p] = sb_busy_s[p];
      end
    end
  end

  assign rs1_data = rd_data_s[0];
  assign rs1_busy = rd_busy_s[0];
  assign rs2_data = rd_data_s[1];
  assign rs2_busy = rd_busy_s[1];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb. One instance with the
// default geometry (32x32, hardwired x0) and one 64-bit x 16 instance without
// a hardwired zero register. Expected bypass behaviour follows REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance signals
  logic        rst, ready, wr_en, alloc_en, flush;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, alloc_addr;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        rs1_busy, rs2_busy;

  // Wide instance signals
  logic        rst2, ready2, wr_en2, alloc_en2, flush2;
  logic [3:0]  rs1_addr2, rs2_addr2, wr_addr2, alloc_addr2;
  logic [63:0] rs1_data2, rs2_data2, wr_data2;
  logic        rs1_busy2, rs2_busy2;

  regfile_sb u_dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .rst(rst2), .ready(ready2),
    .rs1_addr(rs1_addr2), .rs1_data(rs1_data2), .rs1_busy(rs1_busy2),
    .rs2_addr(rs2_addr2), .rs2_data(rs2_data2), .rs2_busy(rs2_busy2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .alloc_en(alloc_en2), .alloc_addr(alloc_addr2), .flush(flush2)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ae;
    logic [4:0]  aa;
    logic        fl;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  exp_t exp_q [$];

  int checks;
  int errors;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ae, input logic [4:0] aa, input logic fl,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] d1, input logic b1,
                              input logic [31:0] d2, input logic b2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ae = ae; v.aa = aa; v.fl = fl;
    v.r1 = r1; v.r2 = r2; v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    alloc_en = 1'b0; alloc_addr = 5'd0; flush = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  task automatic idle2();
    wr_en2 = 1'b0; wr_addr2 = 4'd0; wr_data2 = 64'd0;
    alloc_en2 = 1'b0; alloc_addr2 = 4'd0; flush2 = 1'b0;
    rs1_addr2 = 4'd0; rs2_addr2 = 4'd0;
  endtask

  initial begin
    int n;
    exp_t e;
    checks = 0;
    errors = 0;

    //           we wa     wd            ae aa     fl r1     r2      d1            b1    d2            b2
    vecs[0]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd0,  5'd31,  32'h0,        0, 32'h0,        0);
    vecs[1]  = mk(1, 5'd5,  32'h12345678, 0, 5'd0,  0, 5'd1,  5'd2,   32'h0,        0, 32'h0,        0);
    vecs[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd5,  5'd0,   32'h12345678, 0, 32'h0,        0);
    vecs[3]  = mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  0, 5'd5,  5'd6,   32'h12345678, 0, 32'h0,        0);
    vecs[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd1,  5'd0,   32'h0,        0, 32'h0,        0);
    vecs[5]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  0, 5'd5,  5'd0,   32'h12345678, 0, 32'h0,        0);
    vecs[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd7,  5'd5,   32'h0,        1, 32'h12345678, 0);
    vecs[7]  = mk(1, 5'd7,  32'hA5,       0, 5'd0,  0, 5'd5,  5'd0,   32'h12345678, 0, 32'h0,        0);
    vecs[8]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd7,  5'd5,   32'hA5,       0, 32'h12345678, 0);
    vecs[9]  = mk(1, 5'd7,  32'hB6,       1, 5'd7,  0, 5'd1,  5'd2,   32'h0,        0, 32'h0,        0);
    vecs[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd7,  5'd0,   32'hB6,       1, 32'h0,        0);
    vecs[11] = mk(0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd7,  5'd0,   32'hB6,       1, 32'h0,        0);
    vecs[12] = mk(0, 5'd0,  32'h0,        1, 5'd9,  0, 5'd3,  5'd7,   32'h0,        1, 32'hB6,       1);
    vecs[13] = mk(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd3,  5'd9,   32'h0,        1, 32'h0,        1);
    vecs[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd3,  5'd9,   32'h0,        0, 32'h0,        0);
    vecs[15] = mk(0, 5'd0,  32'h0,        1, 5'd12, 1, 5'd7,  5'd12,  32'hB6,       0, 32'h0,        0);
    vecs[16] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd12, 5'd7,   32'h0,        0, 32'hB6,       0);
    vecs[17] = mk(0, 5'd0,  32'h0,        1, 5'd0,  0, 5'd0,  5'd5,   32'h0,        0, 32'h12345678, 0);
    vecs[18] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd0,  5'd12,  32'h0,        0, 32'h0,        0);
    vecs[19] = mk(1, 5'd13, 32'h13,       0, 5'd0,  0, 5'd1,  5'd2,   32'h0,        0, 32'h0,        0);
    vecs[20] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd13, 5'd5,   32'h13,       0, 32'h12345678, 0);
    vecs[21] = mk(1, 5'd21, 32'h2121,     1, 5'd20, 0, 5'd20, 5'd7,   32'h0,        0, 32'hB6,       0);
    vecs[22] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd20, 5'd21,  32'h0,        1, 32'h2121,     0);

    // Reset state of both instances
    rst = 1'b1; rst2 = 1'b1;
    idle(); idle2();
    #2;
    chk("reset_ready", ready, 0);
    chk("reset_rs1_busy", rs1_busy, 0);
    chk("reset2_ready", ready2, 0);
    tick(); tick();

    // Clear sequence: writes/allocs late in CLEAR must be ignored
    rst = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      if (n == 20) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD;
        alloc_en = 1'b1; alloc_addr = 5'd4;
        rs1_addr = 5'd3; rs2_addr = 5'd4;
      end
      if (n == 25) begin
        chk("clear_rs1_data", rs1_data, 0);
        chk("clear_rs2_busy", rs2_busy, 0);
      end
      tick();
      n++;
    end
    chk("clear_cycles", n, 32);
    chk("clear_ready", ready, 1);
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    chk("clear_ignored_write", rs1_data, 0);
    chk("clear_ignored_alloc", rs2_busy, 0);

    // Every register reads zero and is not busy after the clear
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("cleared_rs1_x%0d", i), {rs1_busy, rs1_data}, 0);
      chk($sformatf("cleared_rs2_x%0d", 31 - i), {rs2_busy, rs2_data}, 0);
    end
    tick();

    // Table-driven vectors through the expectation queue
    for (int v = 0; v < NV; v++) begin
      wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
      alloc_en = vecs[v].ae; alloc_addr = vecs[v].aa; flush = vecs[v].fl;
      rs1_addr = vecs[v].r1; rs2_addr = vecs[v].r2;
      e.idx = v; e.d1 = vecs[v].d1; e.b1 = vecs[v].b1; e.d2 = vecs[v].d2; e.b2 = vecs[v].b2;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_rs1_data", e.idx), rs1_data, e.d1);
      chk($sformatf("vec%0d_rs1_busy", e.idx), rs1_busy, e.b1);
      chk($sformatf("vec%0d_rs2_data", e.idx), rs2_data, e.d2);
      chk($sformatf("vec%0d_rs2_busy", e.idx), rs2_busy, e.b2);
      tick();
    end
    idle();

    // Writeback-to-read in the same cycle
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55; rs1_addr = 5'd4;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("fwd_same_data", rs1_data, 32'h55);
    chk("fwd_same_busy", rs1_busy, 0);
`else
    chk("fwd_same_data", rs1_data, 32'h0);
    chk("fwd_same_busy", rs1_busy, 1);
`endif
    tick();
    idle();
    rs1_addr = 5'd4;
    @(negedge clk);
    chk("fwd_next_data", rs1_data, 32'h55);
    chk("fwd_next_busy", rs1_busy, 0);
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFF; rs2_addr = 5'd0;
    @(negedge clk);
    chk("fwd_x0_data", rs2_data, 0);
    chk("fwd_x0_busy", rs2_busy, 0);
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h66;
    alloc_en = 1'b1; alloc_addr = 5'd4; rs1_addr = 5'd4;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("fwd_alloc_data", rs1_data, 32'h66);
`else
    chk("fwd_alloc_data", rs1_data, 32'h55);
`endif
    chk("fwd_alloc_busy", rs1_busy, 0);
    tick();
    idle();
    rs1_addr = 5'd4;
    @(negedge clk);
    chk("alloc_wr_data", rs1_data, 32'h66);
    chk("alloc_wr_busy", rs1_busy, 1);
    tick();

    // Asynchronous reset in the middle of a cycle
    idle();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h77;
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd11;
    tick();
    idle();
    rs1_addr = 5'd10; rs2_addr = 5'd11;
    @(negedge clk);
    chk("pre_rst_data", rs1_data, 32'h77);
    chk("pre_rst_busy", rs2_busy, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", ready, 0);
    chk("async_rst_busy", rs2_busy, 0);
    chk("async_rst_data", rs1_data, 0);
    tick();
    rst = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk("reclear_cycles", n, 32);
    #1;
    chk("reclear_x10", rs1_data, 0);
    chk("reclear_busy_x11", rs2_busy, 0);

    // Wide instance: 16-entry clear, x0 is an ordinary register
    rst2 = 1'b0;
    n = 0;
    while (!ready2 && n < 100) begin
      tick();
      n++;
    end
    chk("w_clear_cycles", n, 16);
    wr_en2 = 1'b1; wr_addr2 = 4'd0; wr_data2 = 64'h1_0000_0000;
    tick();
    idle2();
    #1;
    chk("w_x0_data", rs1_data2, 64'h1_0000_0000);
    alloc_en2 = 1'b1; alloc_addr2 = 4'd0;
    tick();
    idle2();
    #1;
    chk("w_x0_busy", rs2_busy2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's integer register file.
- Keeps 2 asynchronous read ports and 1 synchronous write port.
- Adds:
  - a configurable width and depth;
  - a hardware clear sequencer after reset, since the array has no per-entry reset;
  - a per-register busy scoreboard that the decode stage uses for RAW hazard detection and stalling.
- Sits between decode (read, allocate) and writeback (write, release).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of 2 and ≥ 2.
- AW, $clog2(NREGS), register address width. Derived; do not override.
- ZERO_REG, 1. When 1, register 0 is hardwired to zero and is never busy. When 0, register 0 is an ordinary register.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- ready  out  1  high once the clear sequence has completed.
- rs1_addr  in  AW  read port 1 address.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs1_busy  out  1  scoreboard bit for rs1_addr, combinational.
- rs2_addr  in  AW  read port 2 address.
- rs2_data  out  XLEN  read port 2 data, combinational.
- rs2_busy  out  1  scoreboard bit for rs2_addr, combinational.
- wr_en  in  1  writeback write enable.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- alloc_en  in  1  decode issues an instruction with a destination register.
- alloc_addr  in  AW  destination register being allocated.
- flush  in  1  clears every busy bit (pipeline flush).

Behaviour:
- Reset is asynchronous while rst=1. During reset:
  - ready=0 and the FSM enters CLEAR with clr_idx=0;
  - all busy bits are 0.
- Register array contents are not reset directly.
- FSM state CLEAR:
  - each cycle writes 0 to registers[clr_idx], then clr_idx increments;
  - after writing NREGS-1, the FSM moves to RUN.
  - The clear therefore takes exactly NREGS cycles after rst deasserts.
  - In CLEAR: read data = 0, busy outputs = 0, and wr_en, alloc_en and flush are ignored.
- FSM state RUN:
  - ready=1, registered (high from the cycle after the last clear write);
  - RUN persists until rst is asserted.
  - rst asserted mid-RUN or mid-CLEAR restarts CLEAR from index 0.
- Read, combinational:
  - rsN_data = registers[rsN_addr];
  - returns 0 when ZERO_REG=1 and rsN_addr==0.
  - Bypass behaviour is covered under Optional Feature.
- Write, synchronous:
  - on posedge, if RUN and wr_en, then registers[wr_addr] <= wr_data;
  - the write is dropped when ZERO_REG=1 and wr_addr==0.
- Scoreboard, synchronous, per register i. Priority is highest first:
  - flush → busy[i]=0;
  - alloc_en && alloc_addr==i → busy[i]=1;
  - wr_en && wr_addr==i → busy[i]=0;
  - otherwise hold.
- Simultaneous alloc and write to the same register: busy stays 1, because the new producer wins. The data write still occurs.
- flush together with alloc_en: flush wins and nothing is allocated.
- When ZERO_REG=1, busy[0] is constant 0 and allocation of register 0 is ignored.
- A write to a non-busy register is legal (in-order retire of a squashed producer): data is written and busy stays 0.
- rsN_busy = busy[rsN_addr], from the registered value. It does not reflect same-cycle alloc or release, except as noted under Optional Feature.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If RUN, wr_en, wr_addr==rsN_addr, and the address is not the hardwired zero register:
    - rsN_data = wr_data in the same cycle;
    - rsN_busy = 0 in the same cycle, unless alloc_en targets that same address.
  - This removes the writeback→decode stall cycle.
- Undefined:
  - reads return the stored value, so the new data is visible the cycle after the write;
  - busy clears on the next edge;
  - the pipeline must stall one extra cycle.

Decomposition:
- Shared package / header regfile_pkg:
  - state encoding constants ST_CLEAR=1'b0, ST_RUN=1'b1;
  - default XLEN and NREGS constants shared with decode/hazard unit.
- One natural sub-module: regfile_scoreboard.
  - Contents: busy vector, priority update, and the two busy lookups.
  - Parameters: NREGS, ZERO_REG.
  - Inputs: alloc/release/flush and the two read addresses.
- The array, clear FSM and bypass mux stay in regfile_sb.

Test Plan:
- Clear sequence, NREGS=32:
  - deassert rst → ready=0 for 32 cycles, then 1;
  - read all registers → 0;
  - wr_en with 0xDEAD during CLEAR → ignored; reg stays 0.
- Basic write/read:
  - write x5=0x12345678 → rs1_addr=5 reads 0x12345678 the next cycle;
  - write x0=0xFFFFFFFF → rs2_addr=0 reads 0 (ZERO_REG=1).
- Scoreboard:
  - alloc x7 → rs1_busy=1 next cycle;
  - write x7=0xA5 → busy=0 next cycle and data=0xA5;
  - alloc x7 and write x7 in the same cycle → busy stays 1;
  - flush with busy set on x3 and x9 → both 0.
- Bypass:
  - with REGFILE_BYPASS_EN, write x4=0x55 with rs1_addr=4 → rs1_data=0x55 and rs1_busy=0 in the same cycle;
  - without it, old value in that cycle, 0x55 the next cycle.
- Reset mid-operation:
  - after writing x10=0x77 and allocating x11, pulse rst for 1 cycle mid-cycle (async) → ready=0 immediately, busy[11]=0;
  - after 32 cycles x10 reads 0.
- Parameter sweep:
  - XLEN=64, NREGS=16, ZERO_REG=0 → clear takes 16 cycles;
  - write x0=0x1_0000_0000 → reads back 0x1_0000_0000;
  - alloc x0 → busy.
